// File: rtl/wrapper_test_hvsync.sv
// VGA test-pattern source: 2:1 pixel strobe, 800x525 raster timing, colour bars
// with a white border, a key-driven paddle and a colour-invert key.
module wrapper_test_hvsync #(
  parameter int PADDLE_W    = 64,
  parameter int PADDLE_STEP = 4,
  parameter int PADDLE_Y0   = 440,
  parameter int PADDLE_H    = 16,
  parameter int PADDLE_X0   = 288,
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int BAR_W       = 80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keys,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb
);

  localparam logic [9:0] H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_L    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L    = 10'(V_VIS);
  localparam logic [9:0] H_VIS_LAST = 10'(H_VIS - 1);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VIS - 1);
  localparam logic [9:0] HS_START   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] PX_MAX     = 10'(H_VIS - PADDLE_W);
  localparam logic [9:0] PX_RST     = 10'(PADDLE_X0);
  localparam logic [9:0] STEP       = 10'(PADDLE_STEP);
  localparam logic [9:0] PW         = 10'(PADDLE_W);
  localparam logic [9:0] PY0        = 10'(PADDLE_Y0);
  localparam logic [9:0] PY1        = 10'(PADDLE_Y0 + PADDLE_H);
  localparam logic [9:0] BAR_LAST   = 10'(BAR_W - 1);

  logic       clk_div;
  logic       pix_en;
  logic [9:0] hcount, vcount, px;
  logic [9:0] bar_pos;
  logic [2:0] bar_idx;
  logic [3:0] key_meta, key_sync;
  logic       h_wrap, v_wrap;
  logic       visible, border, in_paddle;
  logic [2:0] base_rgb, pix_rgb;
  logic [9:0] px_left, px_right;

  always_ff @(posedge clk) begin
    if (!reset) clk_div <= 1'b0;
    else        clk_div <= ~clk_div;
  end

  assign pix_en = ~clk_div;

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      key_meta <= keys;
      key_sync <= key_meta;
    end
  end

  assign h_wrap = (hcount == H_LAST);
  assign v_wrap = (vcount == V_LAST);

  // bar_idx tracks hcount/BAR_W incrementally, avoiding a divider.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hcount  <= '0;
      vcount  <= '0;
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        hcount  <= '0;
        vcount  <= v_wrap ? 10'd0 : vcount + 10'd1;
        bar_pos <= '0;
        bar_idx <= '0;
      end else begin
        hcount <= hcount + 10'd1;
        if (bar_pos == BAR_LAST) begin
          bar_pos <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_pos <= bar_pos + 10'd1;
        end
      end
    end
  end

  always_comb begin
    visible   = (hcount < H_VIS_L) && (vcount < V_VIS_L);
    border    = (hcount == 10'd0) || (hcount == H_VIS_LAST) ||
                (vcount == 10'd0) || (vcount == V_VIS_LAST);
    in_paddle = (hcount >= px) && (hcount < px + PW) &&
                (vcount >= PY0) && (vcount < PY1);
    base_rgb  = bar_idx;
    if (border)         base_rgb = 3'b111;
    else if (in_paddle) base_rgb = 3'b000;
    pix_rgb = 3'b000;
    if (visible) pix_rgb = key_sync[3] ? ~base_rgb : base_rgb;
  end

  // Outputs describe the pixel the counters point at before they advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= 3'b000;
    end else if (pix_en) begin
      hsync <= !((hcount >= HS_START) && (hcount < HS_END));
      vsync <= !((vcount >= VS_START) && (vcount < VS_END));
      rgb   <= pix_rgb;
    end
  end

  assign px_left  = (px >= STEP) ? px - STEP : 10'd0;
  assign px_right = (px + STEP > PX_MAX) ? PX_MAX : px + STEP;

  // Paddle moves once per frame, at the first blank line, so a frame never tears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      px <= PX_RST;
    end else if (pix_en && hcount == 10'd0 && vcount == V_VIS_L) begin
      if (key_sync[2]) begin
        px <= PX_RST;
      end else begin
        case (key_sync[1:0])
          2'b01:   px <= px_left;
          2'b10:   px <= px_right;
          default: px <= px;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wrapper_test_hvsync.sv
// Bench for wrapper_test_hvsync on a shrunken raster (48x20) so many frames fit
// in a short run; expectations come from a per-pixel model of the colour rules.
module tb_wrapper_test_hvsync;

  localparam int H_VIS = 32, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_VIS = 14, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int BAR_W = 4, PADDLE_W = 8, STEP = 5, PY0 = 10, PH = 2, PX0 = 12;
  localparam int PX_MAX = H_VIS - PADDLE_W;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] keys = 4'b1100;
  logic       hsync, vsync;
  logic [2:0] rgb;

  int checks = 0;
  int errors = 0;
  int pix_n = 0;
  int model_px = PX0;

  wrapper_test_hvsync #(
    .PADDLE_W(PADDLE_W), .PADDLE_STEP(STEP), .PADDLE_Y0(PY0), .PADDLE_H(PH),
    .PADDLE_X0(PX0), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .BAR_W(BAR_W)
  ) dut (
    .clk(clk), .reset(reset), .keys(keys), .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] model_rgb(int h, int v);
    logic [2:0] c;
    if (h >= H_VIS || v >= V_VIS) return 3'b000;
    if (h == 0 || h == H_VIS - 1 || v == 0 || v == V_VIS - 1) c = 3'b111;
    else if (h >= model_px && h < model_px + PADDLE_W && v >= PY0 && v < PY0 + PH) c = 3'b000;
    else c = 3'(h / BAR_W);
    return keys[3] ? ~c : c;
  endfunction

  // Advance to the next pixel strobe, sample outputs and produce the model's view.
  task automatic next_pix(output int h, output int v, output int nclk,
                          output logic hs, output logic vs, output logic [2:0] c,
                          output logic ehs, output logic evs, output logic [2:0] ec);
    nclk = 0;
    do begin
      @(posedge clk); #1;
      nclk++;
    end while (dut.clk_div !== 1'b1 && nclk < 4);
    if (dut.clk_div !== 1'b1) begin
      checks++; errors++;
      $display("FAIL strobe_timeout clk_div=%b after %0d clk", dut.clk_div, nclk);
    end
    h = pix_n % HT;
    v = (pix_n / HT) % VT;
    hs = hsync; vs = vsync; c = rgb;
    ehs = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
    evs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
    ec = model_rgb(h, v);
    if (h == 0 && v == V_VIS) begin
      if (keys[2]) model_px = PX0;
      else if (keys[0] && !keys[1]) model_px = (model_px >= STEP) ? model_px - STEP : 0;
      else if (keys[1] && !keys[0]) model_px = (model_px + STEP > PX_MAX) ? PX_MAX : model_px + STEP;
    end
    pix_n++;
  endtask

  task automatic hold_reset(int ncyc, string tag);
    reset = 1'b0;
    keys = 4'b1100;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({hsync, vsync, rgb, dut.clk_div} !== 6'b110000) begin
        errors++;
        $display("FAIL %s hs/vs/rgb/clk_div got %b%b %b %b exp 11 000 0", tag, hsync, vsync, rgb, dut.clk_div);
      end
    end
    @(negedge clk);
    keys = 4'b0000;
    reset = 1'b1;
    pix_n = 0;
    model_px = PX0;
  endtask

  task automatic test_reset();
    hold_reset(7, "reset");
  endtask

  task automatic test_raster();
    int h, v, nclk, hs_low, vs_low;
    logic hs, vs, ehs, evs;
    logic [2:0] c, ec;
    for (int f = 0; f < 2; f++) begin
      vs_low = 0;
      for (int p = 0; p < HT * VT; p++) begin
        next_pix(h, v, nclk, hs, vs, c, ehs, evs, ec);
        checks += 4;
        if (nclk !== ((pix_n == 1) ? 1 : 2)) begin errors++; $display("FAIL strobe_period pix %0d got %0d clk", pix_n - 1, nclk); end
        if (hs !== ehs) begin errors++; $display("FAIL raster_hsync h=%0d v=%0d got %b exp %b", h, v, hs, ehs); end
        if (vs !== evs) begin errors++; $display("FAIL raster_vsync h=%0d v=%0d got %b exp %b", h, v, vs, evs); end
        if (c !== ec) begin errors++; $display("FAIL raster_rgb h=%0d v=%0d got %b exp %b", h, v, c, ec); end
        if (h == 0) hs_low = 0;
        if (!hs) hs_low++;
        if (!vs) vs_low++;
        if (h == HT - 1) begin
          checks++;
          if (hs_low !== H_SYNC) begin errors++; $display("FAIL hsync_width v=%0d got %0d exp %0d", v, hs_low, H_SYNC); end
        end
        if (v == 5 && (h == 5 || h == 30)) begin
          checks++;
          if (c !== ((h == 5) ? 3'b001 : 3'b111)) begin errors++; $display("FAIL bar_sample h=%0d got %b", h, c); end
        end
      end
      checks++;
      if (vs_low !== V_SYNC * HT) begin errors++; $display("FAIL vsync_width got %0d exp %0d", vs_low, V_SYNC * HT); end
    end
    // Park at the start of vertical blanking so later key changes are frame-safe.
    for (int p = 0; p < (V_VIS + 1) * HT; p++) begin
      next_pix(h, v, nclk, hs, vs, c, ehs, evs, ec);
      checks++;
      if ({hs, vs, c} !== {ehs, evs, ec}) begin errors++; $display("FAIL align h=%0d v=%0d got %b%b%b exp %b%b%b", h, v, hs, vs, c, ehs, evs, ec); end
    end
  endtask

  task automatic test_paddle();
    logic [3:0] key_tab[7] = '{4'b0010, 4'b0001, 4'b0011, 4'b0100, 4'b0000, 4'b0010, 4'b0000};
    int frame_tab[7] = '{4, 6, 2, 1, 1, 1, 1};
    int h, v, nclk;
    logic hs, vs, ehs, evs;
    logic [2:0] c, ec;
    for (int s = 0; s < 7 + 4; s++) begin
      @(negedge clk);
      keys = (s < 7) ? key_tab[s] : 4'($urandom_range(0, 15));
      for (int p = 0; p < HT * VT * ((s < 7) ? frame_tab[s] : 1); p++) begin
        next_pix(h, v, nclk, hs, vs, c, ehs, evs, ec);
        checks++;
        if ({hs, vs, c} !== {ehs, evs, ec}) begin
          errors++;
          $display("FAIL paddle step %0d h=%0d v=%0d px=%0d got %b%b%b exp %b%b%b", s, h, v, model_px, hs, vs, c, ehs, evs, ec);
        end
        if (s == 0 && model_px == PX_MAX && v == PY0 && (h == 23 || h == 24 || h == 31)) begin
          checks++;
          if (c !== ((h == 23) ? 3'b101 : (h == 24) ? 3'b000 : 3'b111)) begin
            errors++; $display("FAIL paddle_saturated h=%0d got %b", h, c);
          end
        end
      end
    end
  endtask

  task automatic test_invert();
    int h, v, nclk;
    logic hs, vs, ehs, evs;
    logic [2:0] c, ec;
    @(negedge clk);
    keys = 4'b1000;
    for (int p = 0; p < HT * VT * 2; p++) begin
      next_pix(h, v, nclk, hs, vs, c, ehs, evs, ec);
      checks++;
      if ({hs, vs, c} !== {ehs, evs, ec}) begin errors++; $display("FAIL invert h=%0d v=%0d got %b%b%b exp %b%b%b", h, v, hs, vs, c, ehs, evs, ec); end
      if (v == 5 && (h == 0 || h == 2 || h == 40)) begin
        checks++;
        if (c !== ((h == 2) ? 3'b111 : 3'b000)) begin errors++; $display("FAIL invert_sample h=%0d got %b", h, c); end
      end
    end
    @(negedge clk);
    keys = 4'b0000;
  endtask

  task automatic test_mid_reset();
    int h, v, nclk;
    logic hs, vs, ehs, evs;
    logic [2:0] c, ec;
    for (int p = 0; p < HT * VT / 2; p++) next_pix(h, v, nclk, hs, vs, c, ehs, evs, ec);
    @(negedge clk);
    hold_reset(3, "mid_reset");
    for (int p = 0; p < HT * 3; p++) begin
      next_pix(h, v, nclk, hs, vs, c, ehs, evs, ec);
      checks++;
      if ({hs, vs, c} !== {ehs, evs, ec}) begin errors++; $display("FAIL after_reset h=%0d v=%0d got %b%b%b exp %b%b%b", h, v, hs, vs, c, ehs, evs, ec); end
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_paddle();
    test_invert();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrapper_test_hvsync.md
Name: wrapper_test_hvsync

Overview:
Self-contained VGA 640x480 test-pattern source. It divides the system clock down to a pixel rate and generates 800x525 raster timing with hsync/vsync. It drives a 3-bit RGB colour-bar pattern with a white border and a key-controlled movable paddle. It sits at the top of the display demo, between board keys and the VGA connector.

Parameters:
PADDLE_W, 64, paddle width in pixels
PADDLE_STEP, 4, paddle move per frame in pixels
PADDLE_Y0, 440, first paddle row
PADDLE_H, 16, paddle height in rows

Ports:
clk  in  1  system clock (2x pixel rate)
reset  in  1  synchronous, active-low reset
keys  in  4  [0]=left, [1]=right, [2]=recentre paddle, [3]=invert colours; asynchronous, active-high
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
rgb  out  3  {R,G,B}, one bit per component

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-low (reset==0 resets on the clk edge).
- While in reset: clk_div=0, hcount=0, vcount=0, paddle x=288, key synchronisers=0, hsync=1, vsync=1, rgb=3'b000.
- Internal register named exactly clk_div toggles every clk. Benches probe it hierarchically as the pixel strobe.
- pix_en = (clk_div==0), so all pixel-domain state updates on the clk edge where clk_div rises. One pixel = 2 clk. No derived clocks.
- Counters on pix_en:
  - hcount 0..799, wraps to 0.
  - vcount increments when hcount wraps; range 0..524, wraps to 0.
- Horizontal timing: visible 0..639, front porch 640..655, sync 656..751 (hsync=0), back porch 752..799.
- Vertical timing: visible 0..479, front porch 480..489, sync 490..491 (vsync=0), back porch 492..524.
- hsync, vsync and rgb are registered on pix_en from the pre-increment counter values (one pixel of latency). After reset release, the k-th pix_en loads outputs for pixel index k-1 in raster order. A new frame starts every 420000 pix_en.
- Colour, priority high to low:
  1. Blanking (h>=640 or v>=480): rgb=000.
  2. Border (h==0, h==639, v==0 or v==479): 111.
  3. Paddle (px<=h<px+PADDLE_W and PADDLE_Y0<=v<PADDLE_Y0+PADDLE_H): 000.
  4. Colour bars: rgb = h/80 (bar 0..7, 80 px each).
- Invert: keys[3] inverts all non-blanking colours (bitwise NOT). Blanking stays 000.
- Keys: each bit passes a 2-flop synchroniser in clk. Use the synchronised values only.
- Paddle update: once per frame, on the pix_en with h==0, v==480.
  - keys[2]: px=288. Has priority over left/right.
  - left only: px = (px>=STEP) ? px-STEP : 0.
  - right only: px = min(px+STEP, 640-PADDLE_W).
  - left and right together, or no key: px unchanged.
- px is 10 bits, always within 0..576.
- Reset mid-frame: takes effect on the next clk edge. Counters restart at (0,0); outputs go to the reset values.
- keys[2] and keys[3] have no effect during reset.

Test Plan:
- Reset held low 7 clk, then released -> hsync=vsync=1, rgb=0 during reset; clk_div toggles every clk after release; hsync first low for pixels 656..751 of line 0 (96 pixel strobes).
- Free run 10 frames, sampling rgb/hsync/vsync on each clk_div rise -> every frame is 800x525 samples.
  - vsync low for exactly 2 lines (1600 samples) per frame.
  - hsync low 96 per line.
  - rgb=0 outside 640x480.
- Frame content check -> border rows/cols white (111); row 100 col 85 rgb=001; col 600 rgb=111; paddle at x 288..351, rows 440..455 black.
- Hold keys[1]=1 for 200 frames -> px saturates at 576; paddle spans cols 576..639, and col 639 still shows the white border.
- Hold keys[0]=1 from px=2 with STEP=4 -> px=0 next frame; both keys pressed -> px unchanged; keys[2] pulse -> px=288 at next frame update.
- keys[3]=1 -> visible pixels are bitwise inverted (bar 0 shows 111, border 000); blanking remains 000.
